// File: rtl/modular_add_pipe.sv
// Two-stage pipelined modular adder: T = (a + b) mod qe, with a valid/ready
// handshake on both sides and a sideband tag that follows each operand pair.
module modular_add_pipe #(
  parameter int unsigned TAGW = 8,
  localparam int unsigned W    = 32,
  localparam int unsigned QLOW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            q_load,
  input  logic [W-1:0]    q_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    T,
  output logic [TAGW-1:0] out_tag
);

  // Only the upper bits of the modulus register matter: the low byte of qe
  // is always 8'h01, so q_in[7:0] is never stored.
  logic [W-QLOW-1:0] q_hi_q, q_hi_d;
  logic              unused_q_low;

  // Stage 1: full-width sum plus the modulus it was accepted under.
  logic              s1_valid_q, s1_valid_d;
  logic [W:0]        s1_sum_q, s1_sum_d;
  logic [W-1:0]      s1_qe_q, s1_qe_d;
  logic [TAGW-1:0]   s1_tag_q, s1_tag_d;

  // Stage 2: final result presented on the output port.
  logic              s2_valid_q, s2_valid_d;
  logic [W-1:0]      t_q, t_d;
  logic [TAGW-1:0]   tag_q, tag_d;

  logic [W-1:0]      qe_c;
  logic              s2_adv_c;
  logic [W+1:0]      diff_c;
  logic [W-1:0]      t_c;

  assign unused_q_low = ^q_in[QLOW-1:0];

  // Effective modulus, conditional subtraction and pipeline advance control.
  always_comb begin
    qe_c     = {q_hi_q, 8'h01};
    s2_adv_c = !s2_valid_q || out_ready;
    in_ready = !reset && (!s1_valid_q || s2_adv_c);
    diff_c   = {1'b0, s1_sum_q} - {2'b00, s1_qe_q};
    t_c      = diff_c[W+1] ? s1_sum_q[W-1:0] : diff_c[W-1:0];
  end

  // Next-state for modulus register and both pipeline stages.
  always_comb begin
    q_hi_d     = q_hi_q;
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_qe_d    = s1_qe_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    t_d        = t_q;
    tag_d      = tag_q;

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        t_d   = t_c;
        tag_d = s1_tag_q;
      end
    end

    // Operands sample the modulus as it stood before any same-cycle load.
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d = (W+1)'({1'b0, a}) + (W+1)'({1'b0, b});
        s1_qe_d  = qe_c;
        s1_tag_d = in_tag;
      end
    end

    if (q_load) begin
      q_hi_d = q_in[W-1:QLOW];
    end
  end

  // State registers; reset wins over a simultaneous modulus load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_hi_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_qe_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      t_q        <= '0;
      tag_q      <= '0;
    end else begin
      q_hi_q     <= q_hi_d;
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_qe_q    <= s1_qe_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      t_q        <= t_d;
      tag_q      <= tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign T         = t_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_modular_add_pipe.sv
// Self-checking bench for modular_add_pipe: reference queue model checked on
// every cycle, plus directed vectors with hand-computed results.
module tb_modular_add_pipe;
  localparam int unsigned TAGW = 8;

  logic            clk = 1'b0;
  logic            reset, q_load, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     q_in, a, b, T;
  logic [TAGW-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  modular_add_pipe #(.TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .q_load(q_load), .q_in(q_in),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .T(T), .out_tag(out_tag)
  );

  typedef struct {
    logic [31:0]     t;
    logic [TAGW-1:0] tag;
    int              cyc;
  } exp_ent_t;

  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              last_lat = 0;
  exp_ent_t        mq[$];
  logic [31:0]     log_t[$];
  logic [TAGW-1:0] log_tag[$];
  logic [31:0]     model_q = 32'd0;
  logic            prev_stall = 1'b0;
  logic [31:0]     prev_t = 32'd0;
  logic [TAGW-1:0] prev_tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the effective modulus.
  function automatic logic [31:0] model_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] q);
    logic [63:0] s, m;
    s = 64'(x) + 64'(y);
    m = {32'd0, q[31:8], 8'h01};
    return (s >= m) ? 32'(s - m) : 32'(s);
  endfunction

  // Monitor: sample mid-cycle, compare against the model, track stalls.
  always @(negedge clk) begin : mon
    exp_ent_t e;
    cyc++;
    if (reset) begin
      chk("in_ready_in_reset", 64'(in_ready), 64'(0));
      mq.delete();
      model_q    = 32'd0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(out_valid), 64'(1));
        chk("stall_hold_T", 64'(T), 64'(prev_t));
        chk("stall_hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          chk("model_T", 64'(T), 64'(mq[0].t));
          chk("model_tag", 64'(out_tag), 64'(mq[0].tag));
          if (out_ready) begin
            e = mq.pop_front();
            last_lat = cyc - e.cyc;
            log_t.push_back(T);
            log_tag.push_back(out_tag);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_t     = T;
      prev_tag   = out_tag;
      if (in_valid && in_ready) begin
        e.t   = model_res(a, b, model_q);
        e.tag = in_tag;
        e.cyc = cyc;
        mq.push_back(e);
      end
      if (q_load) model_q = q_in;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [TAGW-1:0] tg);
    bit done;
    done = 1'b0;
    a = x; b = y; in_tag = tg; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    chk("send_accept", 64'(done), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic qload(input logic [31:0] v);
    q_load = 1'b1; q_in = v;
    step(1);
    q_load = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (mq.size() == 0 && !out_valid) done = 1'b1;
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  task automatic clear_log();
    log_t.delete();
    log_tag.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; q_load = 1'b0; q_in = 32'd0; in_valid = 1'b0;
    a = 32'd0; b = 32'd0; in_tag = '0; out_ready = 1'b1;
    step(2);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_T", 64'(T), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    step(1);

    // qe = 12289: basic reduction and latency
    qload(32'h0000_3001);
    clear_log();
    send(32'd12000, 32'd1000, 8'h11);
    drain();
    chk("t1_T", 64'(log_t[0]), 64'd711);
    chk("t1_tag", 64'(log_tag[0]), 64'h11);
    chk("t1_latency", 64'(last_lat), 64'd2);

    // boundaries at the same modulus
    clear_log();
    send(32'd12288, 32'd12288, 8'h01);
    send(32'd0, 32'd0, 8'h02);
    send(32'd12288, 32'd1, 8'h03);
    drain();
    chk("t2_max", 64'(log_t[0]), 64'd12287);
    chk("t2_zero", 64'(log_t[1]), 64'd0);
    chk("t2_eq_qe", 64'(log_t[2]), 64'd0);

    // 33-bit carry path
    qload(32'hFFFF_FF00);
    clear_log();
    send(32'hFFFF_FF00, 32'hFFFF_FF00, 8'h04);
    drain();
    chk("t3_carry", 64'(log_t[0]), 64'hFFFF_FEFF);

    // 8 back-to-back inputs under a 1,0,0 out_ready pattern
    qload(32'h0000_3001);
    clear_log();
    fork
      for (int i = 0; i < 8; i++) send(32'(1500 * i), 32'(1500 * i), TAGW'(i));
      for (int k = 0; k < 45; k++) begin
        @(posedge clk);
        #1;
        out_ready = (k % 3 == 0);
      end
    join
    out_ready = 1'b1;
    drain();
    chk("t4_count", 64'(log_t.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("t4_order", 64'(log_tag[i]), 64'(i));
    chk("t4_r5", 64'(log_t[5]), 64'd2711);
    chk("t4_r7", 64'(log_t[7]), 64'd8711);

    // modulus change with an operand in flight
    clear_log();
    send(32'd3000, 32'd1000, 8'h21);
    qload(32'h0000_0D01);
    send(32'd3000, 32'd1000, 8'h22);
    drain();
    chk("t5_old_qe", 64'(log_t[0]), 64'd4000);
    chk("t5_new_qe", 64'(log_t[1]), 64'd671);

    // operand accepted in the same cycle as a load still uses the old modulus
    clear_log();
    q_load = 1'b1; q_in = 32'h0000_3001;
    send(32'd3000, 32'd1000, 8'h31);
    q_load = 1'b0;
    send(32'd3000, 32'd1000, 8'h32);
    drain();
    chk("t6_same_cycle", 64'(log_t[0]), 64'd671);
    chk("t6_after", 64'(log_t[1]), 64'd4000);

    // reset with both stages full, simultaneous load loses to reset
    out_ready = 1'b0;
    send(32'd1, 32'd2, 8'h41);
    send(32'd3, 32'd4, 8'h42);
    chk("t7_full_valid", 64'(out_valid), 64'(1));
    chk("t7_full_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b1; q_load = 1'b1; q_in = 32'h1234_5678;
    step(1);
    chk("t7_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t7_rst_T", 64'(T), 64'(0));
    chk("t7_rst_tag", 64'(out_tag), 64'(0));
    reset = 1'b0; q_load = 1'b0; out_ready = 1'b1;
    step(6);
    chk("t7_no_stale", 64'(out_valid), 64'(0));
    clear_log();
    send(32'd0, 32'd0, 8'h51);
    send(32'd5, 32'd7, 8'h52);
    drain();
    chk("t7_qe1_zero", 64'(log_t[0]), 64'd0);
    chk("t7_qe1_oor", 64'(log_t[1]), 64'd11);
    chk("t7_tag", 64'(log_tag[1]), 64'h52);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
